// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Brief    : Shared types, bit positions and syndrome helper for SECDED (8,4).
// Revision : 1.0
// ============================================================================
package hamming_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_DOUBLE = 2'b10
    } err_t;

    // Hamming position i lives at code bit 9-i; bit 1 is overall parity.
    localparam int unsigned POS_P1 = 8;
    localparam int unsigned POS_P2 = 7;
    localparam int unsigned POS_D1 = 6;
    localparam int unsigned POS_P3 = 5;
    localparam int unsigned POS_D2 = 4;
    localparam int unsigned POS_D3 = 3;
    localparam int unsigned POS_D4 = 2;
    localparam int unsigned POS_OP = 1;

    function automatic logic [3:1] calc_syndrome(input logic [8:1] code);
        logic [3:1] syn;
        syn[1] = code[POS_P1] ^ code[POS_D1] ^ code[POS_D2] ^ code[POS_D4];
        syn[2] = code[POS_P2] ^ code[POS_D1] ^ code[POS_D3] ^ code[POS_D4];
        syn[3] = code[POS_P3] ^ code[POS_D2] ^ code[POS_D3] ^ code[POS_D4];
        return syn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_code_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : hamming_code_decoder_if
// Brief    : Codeword-in / result-out bundle for the SECDED decoder.
// Revision : 1.0
// ============================================================================
interface hamming_code_decoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [8:1]       code_in;
    logic             cnt_clr;
    logic             out_valid;
    logic [4:1]       data_out;
    logic [2:1]       error;
    logic [8:1]       corrected_code;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    modport master (
        output in_valid, code_in, cnt_clr,
        input  out_valid, data_out, error, corrected_code, corr_cnt, uncorr_cnt
    );

    modport slave (
        input  in_valid, code_in, cnt_clr,
        output out_valid, data_out, error, corrected_code, corr_cnt, uncorr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hamming_syndrome_calc.sv
`default_nettype none
// ============================================================================
// Module   : hamming_syndrome_calc
// Brief    : Combinational syndrome and overall-parity evaluation.
// Revision : 1.0
// ============================================================================
module hamming_syndrome_calc
    import hamming_pkg::*;
(
    input  wire logic [8:1] i_code,
    output logic      [3:1] o_syn,
    output logic            o_pe
);

    assign o_syn = calc_syndrome(i_code);
    assign o_pe  = ^i_code;

endmodule
`default_nettype wire

// File: rtl/hamming_code_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hamming_code_decoder
// Brief    : Registered SECDED (8,4) decoder with saturating error counters.
// Revision : 1.0
// ============================================================================
module hamming_code_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  wire logic               clk,
    input  wire logic               rst_n,
    hamming_code_decoder_if.slave   bus
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [3:1]       w_syn;
    logic             w_pe;
    logic [8:1]       w_flip;
    err_t             w_err;
    logic [8:1]       w_cc;

    logic             r_out_valid;
    logic [4:1]       r_data;
    err_t             r_err;
    logic [8:1]       r_cc;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    hamming_syndrome_calc u_syn (
        .i_code (bus.code_in),
        .o_syn  (w_syn),
        .o_pe   (w_pe)
    );

    // A zero syndrome with bad parity means the overall parity bit itself flipped.
    always_comb begin
        w_flip = '0;
        w_err  = ERR_NONE;
        if (w_pe) begin
            w_err = ERR_SINGLE;
            if (w_syn == 3'd0) begin
                w_flip = 8'h01;
            end else begin
                w_flip = 8'h80 >> (w_syn - 3'd1);
            end
        end else if (w_syn != 3'd0) begin
            w_err = ERR_DOUBLE;
        end
    end

    assign w_cc = bus.code_in ^ w_flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_data       <= '0;
            r_err        <= ERR_NONE;
            r_cc         <= '0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_data <= {w_cc[POS_D1], w_cc[POS_D2], w_cc[POS_D3], w_cc[POS_D4]};
                r_err  <= w_err;
                r_cc   <= w_cc;
            end
            // Clear takes priority over any same-cycle increment.
            if (bus.cnt_clr) begin
                r_corr_cnt   <= '0;
                r_uncorr_cnt <= '0;
            end else if (bus.in_valid) begin
                if (w_err == ERR_SINGLE && r_corr_cnt != C_CNT_MAX) begin
                    r_corr_cnt <= r_corr_cnt + 1'b1;
                end
                if (w_err == ERR_DOUBLE && r_uncorr_cnt != C_CNT_MAX) begin
                    r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.data_out       = r_data;
    assign bus.error          = r_err;
    assign bus.corrected_code = r_cc;
    assign bus.corr_cnt       = r_corr_cnt;
    assign bus.uncorr_cnt     = r_uncorr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hamming_code_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_code_decoder
// Brief    : Directed self-checking bench for the SECDED (8,4) decoder.
// Revision : 1.0
// ============================================================================
module tb_hamming_code_decoder;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    hamming_code_decoder_if #(.CNT_W(16)) bus ();
    hamming_code_decoder_if #(.CNT_W(2))  sbus ();

    hamming_code_decoder #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hamming_code_decoder #(.CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [8:1] code, input logic clr);
        bus.in_valid = v;
        bus.code_in  = code;
        bus.cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sstep(input logic v, input logic [8:1] code);
        sbus.in_valid = v;
        sbus.code_in  = code;
        sbus.cnt_clr  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:1] encode(input logic [4:1] d);
        logic [8:1] c;
        c[8] = d[4] ^ d[3] ^ d[1];
        c[7] = d[4] ^ d[2] ^ d[1];
        c[6] = d[4];
        c[5] = d[3] ^ d[2] ^ d[1];
        c[4] = d[3];
        c[3] = d[2];
        c[2] = d[1];
        c[1] = ^c[8:2];
        return c;
    endfunction

    initial begin
        logic [8:1] enc;
        logic [8:1] w;
        logic [8:1] m;
        logic       sweep_ok_e;
        logic       sweep_ok_d;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.code_in = '0;  bus.cnt_clr = 1'b0;
        sbus.in_valid = 1'b0; sbus.code_in = '0; sbus.cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_data",  16'(bus.data_out), 16'd0);
        chk("rst_err",   16'(bus.error), 16'd0);
        chk("rst_cc",    16'(bus.corrected_code), 16'd0);
        chk("rst_corr",  bus.corr_cnt, 16'd0);
        chk("rst_uncorr", bus.uncorr_cnt, 16'd0);
        rst_n = 1'b1;

        step(1'b1, 8'b10110100, 1'b0);
        chk("clean0_valid", 16'(bus.out_valid), 16'd1);
        chk("clean0_data", 16'(bus.data_out), 16'b1010);
        chk("clean0_err",  16'(bus.error), 16'b00);
        step(1'b1, 8'b11010010, 1'b0);
        chk("clean1_data", 16'(bus.data_out), 16'b0001);
        chk("clean1_err",  16'(bus.error), 16'b00);
        step(1'b1, 8'b01111000, 1'b0);
        chk("clean2_data", 16'(bus.data_out), 16'b1100);
        chk("clean2_err",  16'(bus.error), 16'b00);
        chk("clean2_cc",   16'(bus.corrected_code), 16'b01111000);

        step(1'b1, 8'b10110000, 1'b0);
        chk("d3flip_cc",   16'(bus.corrected_code), 16'b10110100);
        chk("d3flip_data", 16'(bus.data_out), 16'b1010);
        chk("d3flip_err",  16'(bus.error), 16'b01);
        chk("d3flip_corr", bus.corr_cnt, 16'd1);
        step(1'b1, 8'b00111000, 1'b0);
        chk("p2flip_data", 16'(bus.data_out), 16'b1100);
        chk("p2flip_err",  16'(bus.error), 16'b01);
        chk("p2flip_cc",   16'(bus.corrected_code), 16'b01111000);
        step(1'b1, 8'b01111001, 1'b0);
        chk("opflip_data", 16'(bus.data_out), 16'b1100);
        chk("opflip_err",  16'(bus.error), 16'b01);
        chk("opflip_cc",   16'(bus.corrected_code), 16'b01111000);
        chk("opflip_corr", bus.corr_cnt, 16'd3);

        step(1'b1, 8'b01111110, 1'b0);
        chk("dbl_err",    16'(bus.error), 16'b10);
        chk("dbl_data",   16'(bus.data_out), 16'b1111);
        chk("dbl_cc",     16'(bus.corrected_code), 16'b01111110);
        chk("dbl_uncorr", bus.uncorr_cnt, 16'd1);
        chk("dbl_corr",   bus.corr_cnt, 16'd3);

        step(1'b0, 8'b10110100, 1'b0);
        chk("idle_valid", 16'(bus.out_valid), 16'd0);
        chk("idle_data",  16'(bus.data_out), 16'b1111);
        chk("idle_err",   16'(bus.error), 16'b10);

        step(1'b0, 8'h00, 1'b1);
        chk("clr_corr",   bus.corr_cnt, 16'd0);
        chk("clr_uncorr", bus.uncorr_cnt, 16'd0);

        sweep_ok_e = 1'b1;
        sweep_ok_d = 1'b1;
        for (int d = 0; d < 16; d++) begin
            enc = encode(4'(d));
            for (int i = 1; i <= 8; i++) begin
                m = 8'(8'd1 << (i - 1));
                w = enc ^ m;
                step(1'b1, w, 1'b0);
                if (bus.error !== 2'b01 || bus.data_out !== 4'(d)) sweep_ok_e = 1'b0;
                for (int j = i + 1; j <= 8; j++) begin
                    w = enc ^ m ^ 8'(8'd1 << (j - 1));
                    step(1'b1, w, 1'b0);
                    if (bus.error !== 2'b10) sweep_ok_d = 1'b0;
                end
            end
        end
        chk("sweep_single", 16'(sweep_ok_e), 16'd1);
        chk("sweep_double", 16'(sweep_ok_d), 16'd1);
        chk("sweep_corr",   bus.corr_cnt, 16'd128);
        chk("sweep_uncorr", bus.uncorr_cnt, 16'd448);

        step(1'b1, 8'b10110000, 1'b1);
        chk("clrwin_err",    16'(bus.error), 16'b01);
        chk("clrwin_corr",   bus.corr_cnt, 16'd0);
        chk("clrwin_uncorr", bus.uncorr_cnt, 16'd0);

        step(1'b1, 8'b10110000, 1'b0);
        bus.in_valid = 1'b1;
        bus.code_in  = 8'b01111110;
        rst_n = 1'b0;
        #1;
        chk("amid_valid", 16'(bus.out_valid), 16'd0);
        chk("amid_data",  16'(bus.data_out), 16'd0);
        chk("amid_err",   16'(bus.error), 16'd0);
        chk("amid_cc",    16'(bus.corrected_code), 16'd0);
        chk("amid_corr",  bus.corr_cnt, 16'd0);
        @(posedge clk);
        #1;
        chk("rsthold_valid", 16'(bus.out_valid), 16'd0);
        chk("rsthold_uncorr", bus.uncorr_cnt, 16'd0);
        rst_n = 1'b1;
        step(1'b1, 8'b11010010, 1'b0);
        chk("postrst_valid", 16'(bus.out_valid), 16'd1);
        chk("postrst_data",  16'(bus.data_out), 16'b0001);
        bus.in_valid = 1'b0;

        for (int k = 1; k <= 4; k++) begin
            sstep(1'b1, 8'b10110000);
            chk($sformatf("sat_corr_%0d", k), 16'(sbus.corr_cnt), (k < 3) ? 16'(k) : 16'd3);
        end
        for (int k = 1; k <= 4; k++) begin
            sstep(1'b1, 8'b01111110);
        end
        chk("sat_uncorr", 16'(sbus.uncorr_cnt), 16'd3);
        chk("sat_corr_hold", 16'(sbus.corr_cnt), 16'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_code_decoder.md
# hamming_code_decoder

Registered SECDED decoder for the extended Hamming (8,4) code. Each input word carries 4 data bits, 3 Hamming parity bits and 1 overall parity bit. The block corrects any single-bit error, flags double-bit errors, and keeps saturating error statistics. It sits on the receive side of a memory or link path, after storage or transport and before the data consumer.

## Interface
- CNT_W, 16, width of the error statistics counters.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  code_in is valid this cycle.
- code_in  in  [8:1]  received codeword.
- cnt_clr  in  1  synchronous clear of both counters.
- out_valid  out  1  registered outputs hold a new result.
- data_out  out  [4:1]  decoded data (d1 on bit 4, d4 on bit 1).
- error  out  [2:1]  status: 00 clean, 01 single corrected, 10 double detected, 11 never driven.
- corrected_code  out  [8:1]  codeword after correction.
- corr_cnt  out  [CNT_W-1:0]  count of single-error events (saturating).
- uncorr_cnt  out  [CNT_W-1:0]  count of double-error events (saturating).

## Operation
- **Bit mapping.** Hamming position i (1..7) is code_in[9-i], so code_in[8]=p1, [7]=p2, [6]=d1, [5]=p3, [4]=d2, [3]=d3, [2]=d4. code_in[1] is even parity over code_in[8:2].
- **Encoder definition** (for reference vectors):
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p3 = d2^d3^d4
  - code_in[1] = XOR of code_in[8:2]
- **Syndrome.** syn = {s3,s2,s1}:
  - s1 = XOR of positions 1,3,5,7
  - s2 = XOR of positions 2,3,6,7
  - s3 = XOR of positions 4,5,6,7
- **Overall parity.** pe = XOR of code_in[8:1].
- **Classification:**
  - syn=0, pe=0: error=00; corrected_code = code_in.
  - syn=0, pe=1: error=01; flip code_in[1]; data unchanged.
  - syn≠0, pe=1: error=01; flip position syn, i.e. code_in[9-syn].
  - syn≠0, pe=0: error=10; no flip; corrected_code = code_in; data_out = raw data bits.
- **Data output.** data_out = {cc[6], cc[4], cc[3], cc[2]}, where cc = corrected_code.
- **Three or more bit errors** are undefined by the code and may be miscorrected. The block behaves purely per the classification above.
- **Counters:**
  - corr_cnt increments on each accepted word with error=01.
  - uncorr_cnt increments on each accepted word with error=10.
  - Both saturate at all-ones.
  - cnt_clr zeroes both; cnt_clr wins over a simultaneous increment.

## Timing
- Latency is 1 cycle. in_valid=1 at edge N gives out_valid=1 with results registered at edge N.
- No backpressure; a new word can be accepted every cycle.
- in_valid=0 at an edge: out_valid goes to 0, and data_out, error and corrected_code hold their previous values.
- Reset values (asynchronous): out_valid=0, data_out=0, error=00, corrected_code=0, corr_cnt=0, uncorr_cnt=0.
- Reset asserted mid-stream discards any in-flight word. The first word sampled after rst_n deassertion is processed normally.
- Counters update on the same edge as the registered result.

## Structure
- Package hamming_pkg holds:
  - the error status typedef (ERR_NONE=2'b00, ERR_SINGLE=2'b01, ERR_DOUBLE=2'b10);
  - constants for data/parity bit positions;
  - a function computing the 3-bit syndrome.
- Sub-module hamming_syndrome_calc: combinational; inputs code[8:1]; outputs syn[3:1] and pe.
- The top level holds the correction mux, the output registers and the counters.

## Test plan
- Clean words:
  - 10110100 -> data_out=1010, error=00.
  - 11010010 -> data_out=0001, error=00.
  - 01111000 -> data_out=1100, error=00.
- Single data-bit error: 10110000 (d3 flipped) -> corrected_code=10110100, data_out=1010, error=01, corr_cnt +1.
- Single parity-bit errors:
  - 00111000 (p2 flipped) -> data_out=1100, error=01.
  - 01111001 (overall parity flipped) -> data_out=1100, error=01.
- Double error: 01111110 (d3 and d4 flipped) -> error=10, data_out=1111 (raw, uncorrected), uncorr_cnt +1.
- Exhaustive sweep:
  - all 16 data values encoded per the encoder definition, each with every single-bit flip -> always error=01 and the original data.
  - every double flip -> always error=10.
- Control:
  - reset mid-stream -> all outputs 0 immediately.
  - cnt_clr asserted in the same cycle as an error event -> counter reads 0.
  - counter saturation with CNT_W=2 -> holds at 3.
